// File: rtl/mult_seq_ctrl.sv
// Sequencer for the three-product 16x16 multiplier cell: one or two passes per 32x32 request,
// partial-product combination and signed high-word correction.
module mult_seq_ctrl #(
   parameter int unsigned CELL_LAT = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        busy,
   output logic [31:0] cell_src1,
   output logic [31:0] cell_src2,
   output logic        cell_en,
   input  logic [31:0] cell_p1,
   input  logic [31:0] cell_p2,
   input  logic [31:0] cell_p3
);

   if (CELL_LAT < 1 || CELL_LAT > 3) begin : g_bad_lat
      $error("mult_seq_ctrl: CELL_LAT must be in 1..3");
   end

   typedef enum logic [2:0] {
      StIdle,
      StIssue1,
      StCap1,
      StIssue2,
      StCap2,
      StResp
   } state_e;

   localparam logic [1:0] OpMul = 2'd0;
   localparam logic [1:0] OpXss = 2'd2;
   localparam logic [1:0] OpXsu = 2'd3;

   localparam logic [1:0] LastIss1 = 2'(CELL_LAT - 1);
   localparam logic [1:0] LastIss2 = (CELL_LAT > 1) ? 2'(CELL_LAT - 2) : 2'd0;

   state_e      r_state;
   logic [1:0]  r_cnt;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [1:0]  r_op;
   logic [16:0] r_mid_hi;
   logic        r_carry;
   logic        r_cell_en;
   logic [31:0] r_src1;
   logic [31:0] r_src2;
   logic [31:0] r_rsp_data;

   logic [32:0] w_mid;
   logic [32:0] w_sum;
   logic [31:0] w_hi_u;
   logic [31:0] w_hi_res;

   // Pass 1 gives the low word plus what spills into the high word; pass 2 adds hi*hi.
   always_comb begin
      w_mid    = {1'b0, cell_p2} + {1'b0, cell_p3};
      w_sum    = {1'b0, cell_p1} + {1'b0, w_mid[15:0], 16'h0};
      w_hi_u   = cell_p1 + {15'h0, r_mid_hi} + {31'h0, r_carry};
      w_hi_res = w_hi_u;
      case (r_op)
         OpXss:   w_hi_res = w_hi_u - (r_a[31] ? r_b : 32'h0) - (r_b[31] ? r_a : 32'h0);
         OpXsu:   w_hi_res = w_hi_u - (r_a[31] ? r_b : 32'h0);
         default: w_hi_res = w_hi_u;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= StIdle;
         r_cnt      <= 2'd0;
         r_a        <= 32'h0;
         r_b        <= 32'h0;
         r_op       <= 2'd0;
         r_mid_hi   <= 17'h0;
         r_carry    <= 1'b0;
         r_cell_en  <= 1'b0;
         r_src1     <= 32'h0;
         r_src2     <= 32'h0;
         r_rsp_data <= 32'h0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (req_valid) begin
                  r_a       <= req_a;
                  r_b       <= req_b;
                  r_op      <= req_op;
                  r_cnt     <= 2'd0;
                  r_cell_en <= 1'b1;
                  r_src1    <= req_a;
                  r_src2    <= req_b;
                  r_state   <= StIssue1;
               end
            end
            StIssue1: begin
               if (r_cnt == LastIss1) begin
                  r_cnt   <= 2'd0;
                  r_state <= StCap1;
                  // High ops launch pass 2 while pass 1 is being captured.
                  if (r_op == OpMul) begin
                     r_cell_en <= 1'b0;
                     r_src1    <= 32'h0;
                     r_src2    <= 32'h0;
                  end else begin
                     r_cell_en <= 1'b1;
                     r_src1    <= {16'h0, r_a[31:16]};
                     r_src2    <= {16'h0, r_b[31:16]};
                  end
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            StCap1: begin
               r_mid_hi <= w_mid[32:16];
               r_carry  <= w_sum[32];
               if (r_op == OpMul) begin
                  r_rsp_data <= w_sum[31:0];
                  r_state    <= StResp;
               end else if (CELL_LAT == 1) begin
                  r_cell_en <= 1'b0;
                  r_src1    <= 32'h0;
                  r_src2    <= 32'h0;
                  r_state   <= StCap2;
               end else begin
                  r_state <= StIssue2;
               end
            end
            StIssue2: begin
               if (r_cnt == LastIss2) begin
                  r_cnt     <= 2'd0;
                  r_cell_en <= 1'b0;
                  r_src1    <= 32'h0;
                  r_src2    <= 32'h0;
                  r_state   <= StCap2;
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            StCap2: begin
               r_rsp_data <= w_hi_res;
               r_state    <= StResp;
            end
            StResp: begin
               if (rsp_ready) begin
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign req_ready = (r_state == StIdle);
   assign busy      = (r_state != StIdle);
   assign rsp_valid = (r_state == StResp);
   assign rsp_data  = r_rsp_data;
   assign cell_en   = r_cell_en;
   assign cell_src1 = r_src1;
   assign cell_src2 = r_src2;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: two instances (CELL_LAT=1 and 3), each with a behavioural cell,
// checked against a 64-bit arithmetic reference.
module tb_mult_seq_ctrl;

   logic        clk;
   logic        reset_n;
   logic        req_valid [2];
   logic        req_ready [2];
   logic [1:0]  req_op    [2];
   logic [31:0] req_a     [2];
   logic [31:0] req_b     [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_data  [2];
   logic        busy      [2];
   logic [31:0] cell_src1 [2];
   logic [31:0] cell_src2 [2];
   logic        cell_en   [2];
   logic [31:0] cell_p1   [2];
   logic [31:0] cell_p2   [2];
   logic [31:0] cell_p3   [2];

   int checks;
   int failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int unsigned Lat = (g == 0) ? 1 : 3;
      logic [95:0] r_pipe [Lat];

      // Cell model: Lat enabled stages, cleared by the inverted reset.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int i = 0; i < Lat; i++) r_pipe[i] <= '0;
         end else if (cell_en[g]) begin
            r_pipe[0] <= {32'(cell_src1[g][15:0]) * 32'(cell_src2[g][15:0]),
                          32'(cell_src1[g][15:0]) * 32'(cell_src2[g][31:16]),
                          32'(cell_src1[g][31:16]) * 32'(cell_src2[g][15:0])};
            for (int i = 1; i < Lat; i++) r_pipe[i] <= r_pipe[i-1];
         end
      end

      assign cell_p1[g] = r_pipe[Lat-1][95:64];
      assign cell_p2[g] = r_pipe[Lat-1][63:32];
      assign cell_p3[g] = r_pipe[Lat-1][31:0];

      mult_seq_ctrl #(.CELL_LAT(Lat)) u_dut (
         .clk       (clk),
         .reset_n   (reset_n),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_op    (req_op[g]),
         .req_a     (req_a[g]),
         .req_b     (req_b[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_data  (rsp_data[g]),
         .busy      (busy[g]),
         .cell_src1 (cell_src1[g]),
         .cell_src2 (cell_src2[g]),
         .cell_en   (cell_en[g]),
         .cell_p1   (cell_p1[g]),
         .cell_p2   (cell_p2[g]),
         .cell_p3   (cell_p3[g])
      );
   end

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] uu;
      longint      ss;
      longint      su;
      uu = {32'h0, a} * {32'h0, b};
      ss = longint'($signed(a)) * longint'($signed(b));
      su = longint'($signed(a)) * longint'({32'h0, b});
      case (op)
         2'd0:    return uu[31:0];
         2'd1:    return uu[63:32];
         2'd2:    return ss[63:32];
         default: return su[63:32];
      endcase
   endfunction

   function automatic int exp_lat(input int k, input logic [1:0] op);
      return (op == 2'd0) ? lat_of(k) + 2 : 2 * lat_of(k) + 2;
   endfunction

   function automatic logic [31:0] rand_opnd();
      logic [31:0] ext [4];
      ext[0] = 32'h0; ext[1] = 32'hFFFF_FFFF; ext[2] = 32'h8000_0000; ext[3] = 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) return ext[$urandom_range(0, 3)];
      return $urandom;
   endfunction

   // Presents one request and returns just after its accept edge.
   task automatic issue(input int k, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      @(negedge clk);
      req_valid[k] = 1'b1;
      req_op[k]    = op;
      req_a[k]     = a;
      req_b[k]     = b;
      for (int i = 0; i < 40 && !req_ready[k]; i++) @(negedge clk);
      @(posedge clk);
      #1;
      req_valid[k] = 1'b0;
      req_op[k]    = 2'($urandom);
      req_a[k]     = $urandom;
      req_b[k]     = $urandom;
   endtask

   // Starts just after an accept edge; counts cycles (accept cycle = 0) until rsp_valid.
   task automatic wait_rsp(input int k, output int lat, output int en_cnt,
                           output logic [31:0] s1, output logic [31:0] s2,
                           output logic [31:0] data, output bit src_bad);
      lat = 1; en_cnt = 0; s1 = 0; s2 = 0; src_bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (rsp_valid[k]) break;
         if (cell_en[k]) begin
            en_cnt++;
            s1 = cell_src1[k];
            s2 = cell_src2[k];
         end else if (cell_src1[k] != 0 || cell_src2[k] != 0) begin
            src_bad = 1;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      if (cell_en[k] || cell_src1[k] != 0 || cell_src2[k] != 0) src_bad = 1;
      data = rsp_data[k];
   endtask

   task automatic run_op(input int k, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat, output int en_cnt,
                         output logic [31:0] s1, output logic [31:0] s2,
                         output logic [31:0] data, output bit src_bad);
      issue(k, op, a, b);
      wait_rsp(k, lat, en_cnt, s1, s2, data, src_bad);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 2; k++) begin
         checks += 7;
         if (req_ready[k] !== 1'b1) begin
            failures++; $display("FAIL reset_req_ready[%0d] got=%b exp=1", k, req_ready[k]);
         end
         if (rsp_valid[k] !== 1'b0) begin
            failures++; $display("FAIL reset_rsp_valid[%0d] got=%b exp=0", k, rsp_valid[k]);
         end
         if (rsp_data[k] !== 32'h0) begin
            failures++; $display("FAIL reset_rsp_data[%0d] got=%h exp=0", k, rsp_data[k]);
         end
         if (busy[k] !== 1'b0) begin
            failures++; $display("FAIL reset_busy[%0d] got=%b exp=0", k, busy[k]);
         end
         if (cell_en[k] !== 1'b0) begin
            failures++; $display("FAIL reset_cell_en[%0d] got=%b exp=0", k, cell_en[k]);
         end
         if (cell_src1[k] !== 32'h0) begin
            failures++; $display("FAIL reset_src1[%0d] got=%h exp=0", k, cell_src1[k]);
         end
         if (cell_src2[k] !== 32'h0) begin
            failures++; $display("FAIL reset_src2[%0d] got=%h exp=0", k, cell_src2[k]);
         end
      end
   endtask

   task automatic test_directed();
      logic [1:0]  ops  [6];
      logic [31:0] va   [6];
      logic [31:0] vb   [6];
      logic [31:0] vexp [6];
      int lat, en_cnt;
      logic [31:0] s1, s2, data;
      bit src_bad;
      ops[0] = 2'd0; va[0] = 32'h0001_0003; vb[0] = 32'h0002_0005; vexp[0] = 32'h000B_000F;
      ops[1] = 2'd1; va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFFF; vexp[1] = 32'hFFFF_FFFE;
      ops[2] = 2'd2; va[2] = 32'hFFFF_FFFF; vb[2] = 32'h0000_0002; vexp[2] = 32'hFFFF_FFFF;
      ops[3] = 2'd2; va[3] = 32'h8000_0000; vb[3] = 32'h8000_0000; vexp[3] = 32'h4000_0000;
      ops[4] = 2'd3; va[4] = 32'hFFFF_FFFF; vb[4] = 32'hFFFF_FFFF; vexp[4] = 32'hFFFF_FFFF;
      ops[5] = 2'd3; va[5] = 32'h0000_0002; vb[5] = 32'hFFFF_FFFF; vexp[5] = 32'h0000_0001;
      for (int t = 0; t < 6; t++) begin
         run_op(0, ops[t], va[t], vb[t], lat, en_cnt, s1, s2, data, src_bad);
         checks += 4;
         if (data !== vexp[t]) begin
            failures++; $display("FAIL dir_data[%0d] got=%h exp=%h", t, data, vexp[t]);
         end
         if (lat != ((ops[t] == 2'd0) ? 3 : 4)) begin
            failures++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", t, lat,
                                 (ops[t] == 2'd0) ? 3 : 4);
         end
         if (en_cnt != ((ops[t] == 2'd0) ? 1 : 2)) begin
            failures++; $display("FAIL dir_en_cycles[%0d] got=%0d exp=%0d", t, en_cnt,
                                 (ops[t] == 2'd0) ? 1 : 2);
         end
         if (src_bad) begin
            failures++; $display("FAIL dir_idle_src[%0d] got=nonzero exp=zero", t);
         end
         if (t == 1) begin
            checks++;
            if (s1 !== 32'h0000_FFFF || s2 !== 32'h0000_FFFF) begin
               failures++; $display("FAIL dir_pass2_src got=%h/%h exp=0000ffff/0000ffff", s1, s2);
            end
         end
      end
   endtask

   task automatic test_random(input int k);
      int lat, en_cnt;
      logic [31:0] s1, s2, data, a, b, exp;
      logic [1:0] op;
      bit src_bad;
      for (int t = 0; t < 30; t++) begin
         op = 2'($urandom);
         a = rand_opnd();
         b = rand_opnd();
         exp = ref_mul(op, a, b);
         run_op(k, op, a, b, lat, en_cnt, s1, s2, data, src_bad);
         checks += 3;
         if (data !== exp) begin
            failures++;
            $display("FAIL rnd_data[%0d] op=%0d a=%h b=%h got=%h exp=%h", k, op, a, b, data, exp);
         end
         if (lat != exp_lat(k, op)) begin
            failures++;
            $display("FAIL rnd_latency[%0d] op=%0d got=%0d exp=%0d", k, op, lat, exp_lat(k, op));
         end
         if (en_cnt != ((op == 2'd0) ? lat_of(k) : 2 * lat_of(k)) || src_bad) begin
            failures++;
            $display("FAIL rnd_cell_en[%0d] op=%0d got_en=%0d src_bad=%0b", k, op, en_cnt,
                     src_bad);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat, en_cnt;
      logic [31:0] s1, s2, data, a, b, a2, b2, exp;
      bit src_bad;
      a = $urandom; b = $urandom; a2 = $urandom; b2 = $urandom;
      exp = ref_mul(2'd2, a, b);
      rsp_ready[0] = 1'b0;
      issue(0, 2'd2, a, b);
      wait_rsp(0, lat, en_cnt, s1, s2, data, src_bad);
      @(negedge clk);
      req_valid[0] = 1'b1; req_op[0] = 2'd0; req_a[0] = a2; req_b[0] = b2;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== exp || req_ready[0] !== 1'b0 ||
             cell_en[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold[%0d] valid=%b data=%h exp=%h ready=%b en=%b", i,
                     rsp_valid[0], rsp_data[0], exp, req_ready[0], cell_en[0]);
         end
      end
      @(negedge clk);
      rsp_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (busy[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
         failures++;
         $display("FAIL bp_release got busy=%b valid=%b ready=%b exp 0/0/1", busy[0],
                  rsp_valid[0], req_ready[0]);
      end
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      checks++;
      if (busy[0] !== 1'b1) begin
         failures++; $display("FAIL bp_second_accept got busy=%b exp=1", busy[0]);
      end
      wait_rsp(0, lat, en_cnt, s1, s2, data, src_bad);
      checks += 2;
      if (data !== ref_mul(2'd0, a2, b2)) begin
         failures++; $display("FAIL bp_second_data got=%h exp=%h", data, ref_mul(2'd0, a2, b2));
      end
      if (lat != 3) begin
         failures++; $display("FAIL bp_second_latency got=%0d exp=3", lat);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int lat, en_cnt;
      logic [31:0] s1, s2, data, a, b;
      bit src_bad, seen;
      a = $urandom; b = $urandom;
      issue(1, 2'd1, a, b);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (cell_en[1] !== 1'b1 || cell_src1[1] !== {16'h0, a[31:16]} ||
          cell_src2[1] !== {16'h0, b[31:16]}) begin
         failures++;
         $display("FAIL rm_pass2_src got en=%b src=%h/%h exp 1/%h/%h", cell_en[1],
                  cell_src1[1], cell_src2[1], {16'h0, a[31:16]}, {16'h0, b[31:16]});
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (rsp_valid[1] !== 1'b0 || cell_en[1] !== 1'b0 || busy[1] !== 1'b0 ||
          cell_src1[1] !== 32'h0 || cell_src2[1] !== 32'h0) begin
         failures++;
         $display("FAIL rm_async_reset got valid=%b en=%b busy=%b src=%h/%h exp all 0",
                  rsp_valid[1], cell_en[1], busy[1], cell_src1[1], cell_src2[1]);
      end
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (rsp_valid[1] || busy[1]) seen = 1;
      end
      checks++;
      if (seen) begin
         failures++; $display("FAIL rm_no_response got=activity exp=idle");
      end
      run_op(1, 2'd0, 32'd7, 32'd6, lat, en_cnt, s1, s2, data, src_bad);
      checks += 2;
      if (data !== 32'h0000_002A) begin
         failures++; $display("FAIL rm_next_data got=%h exp=0000002a", data);
      end
      if (lat != 5) begin
         failures++; $display("FAIL rm_next_latency got=%0d exp=5", lat);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         req_valid[k] = 1'b0;
         req_op[k]    = 2'd0;
         req_a[k]     = 32'h0;
         req_b[k]     = 32'h0;
         rsp_ready[k] = 1'b1;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      test_reset();
      test_directed();
      test_random(0);
      test_random(1);
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequencer for the three-product 16x16 multiplier cell in the CPU execute/memory stage. The cell produces lo*lo, lo(a)*hi(b) and hi(a)*lo(b).
- Accepts one 32x32 multiply request at a time, issues one or two passes through the cell, combines the partial products, and returns a 32-bit result.
- MUL returns the low word. MULXUU, MULXSS and MULXSU return the high word; a second pass computes hi*hi and signed correction is applied.

Parameters:
- CELL_LAT, 1, register stages in the cell between src inputs and p outputs (legal 1..3).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset; also drives the cell's clear through inversion
- req_valid  in  1  request present
- req_ready  out  1  controller can accept
- req_op  in  2  0=MUL, 1=MULXUU, 2=MULXSS, 3=MULXSU (a signed, b unsigned)
- req_a  in  32  operand a
- req_b  in  32  operand b
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  32  result word
- busy  out  1  state != IDLE
- cell_src1  out  32  to cell src1
- cell_src2  out  32  to cell src2
- cell_en  out  1  cell clock enable
- cell_p1  in  32  lo*lo (pass 2: hi*hi)
- cell_p2  in  32  a_lo*b_hi
- cell_p3  in  32  a_hi*b_lo

Behaviour:
- Reset (async, reset_n=0): state=IDLE, counter=0, all operand/accumulator registers 0. req_ready=1 once reset_n=1. rsp_valid=0, rsp_data=0, busy=0, cell_en=0, cell_src1=cell_src2=0.
- Accept: edge where req_valid & req_ready. Latch a, b, op. Go to ISSUE1. req_ready=1 only in IDLE.
- ISSUE1 (duration CELL_LAT cycles, counter):
  - cell_src1=a, cell_src2=b, cell_en=1.
  - After CELL_LAT cycles, go to CAP1.
  - Operands are held for all CELL_LAT cycles; en stays high so the cell pipeline advances.
- CAP1 (1 cycle): p1..p3 reflect pass 1.
  - Compute mid = p2 + p3 (33 bit).
  - s = p1 + {mid[15:0],16'h0} (33 bit); lo = s[31:0], c = s[32].
  - Register mid[32:16] and c.
  - If op=MUL: rsp_data<=lo, go to RESP, cell_en=0.
  - Else, in the same cycle: cell_src1={16'h0,a[31:16]}, cell_src2={16'h0,b[31:16]}, cell_en=1. Go to ISSUE2.
- ISSUE2 (CELL_LAT-1 further cycles; skipped when CELL_LAT=1):
  - Pass-2 sources held, cell_en=1.
  - Then go to CAP2.
- CAP2 (1 cycle): hh = cell_p1.
  - hi_u = hh + mid[32:16] + c (mod 2^32).
  - MULXUU: hi_u.
  - MULXSS: hi_u - (a[31]?b:0) - (b[31]?a:0).
  - MULXSU: hi_u - (a[31]?b:0).
  - All mod 2^32. rsp_data<=result. Go to RESP. cell_en=0.
- RESP:
  - rsp_valid=1, rsp_data stable, cell_en=0, req_ready=0.
  - On rsp_ready go to IDLE; rsp_valid drops the next cycle.
  - No accept on the same edge as the response handshake.
- Latency, accept edge to first rsp_valid cycle:
  - MUL: CELL_LAT+2.
  - High ops: 2*CELL_LAT+2.
  - CELL_LAT=1 gives 3 and 4.
- cell_src outputs are 0 whenever cell_en=0. cell_en=0 in IDLE and RESP, so cell outputs are frozen outside operation.
- req_valid during busy: ignored, no side effect. req_op/a/b changing after accept: no effect.
- Reset mid-operation: in-flight request discarded, no response; the cell is cleared by the same reset.
- Operand extremes (0, 0xFFFFFFFF) wrap mod 2^32 exactly as above; no overflow flags.

Test Plan:
- CELL_LAT=1, MUL a=0x00010003 b=0x00020005 -> rsp_data=0x000B000F, rsp_valid first high 3 cycles after accept; cell_en high exactly 1 cycle.
- MULXUU a=b=0xFFFFFFFF -> rsp_data=0xFFFFFFFE at 4 cycles; pass-2 cell_src1=cell_src2=0x0000FFFF.
- MULXSS a=0xFFFFFFFF b=0x00000002 -> 0xFFFFFFFF. MULXSS a=0x80000000 b=0x80000000 -> 0x40000000.
- MULXSU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFF. MULXSU a=0x00000002 b=0xFFFFFFFF -> 0x00000001.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid with a second req_valid pending -> rsp_data stable, req_ready=0, cell_en=0. The second request is accepted only the cycle after the response handshake, and its result is correct.
- Reset pulse during ISSUE2, CELL_LAT=3 -> immediately rsp_valid=0, cell_en=0, busy=0, no response ever for that request. The next request MUL 7*6 returns 0x0000002A after 5 cycles.
